// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle between decode, alu_seq and writeback.
// The sat wire exists only when ALU_SAT_FLAG_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH = 11
);
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              inst;
  logic signed [WIDTH-1:0] arg1;
  logic signed [WIDTH-1:0] arg2;
  logic signed [WIDTH-1:0] acc;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out;
`ifdef ALU_SAT_FLAG_EN
  logic                    sat;
`endif

  modport master (
    output in_valid, inst, arg1, arg2, acc, out_ready,
    input  in_ready, out_valid, out
`ifdef ALU_SAT_FLAG_EN
    , input sat
`endif
  );

  modport slave (
    input  in_valid, inst, arg1, arg2, acc, out_ready,
    output in_ready, out_valid, out
`ifdef ALU_SAT_FLAG_EN
    , output sat
`endif
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle saturating accumulator ALU (add/sub/mul/not/dgt/dst/pass)
// behind a valid/ready handshake. Define ALU_SAT_FLAG_EN to add the sat output,
// which flags results that had to be clamped to +/-LIMIT.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// MUL   | shift-add multiply, one multiplier bit per cycle
// B2D   | double-dabble |acc| into BCD, then pick/replace the addressed digit
// D2B   | Horner x10 recombination of the BCD digits (dst only)
// DONE  | result held on out with out_valid until out_ready
module alu_seq #(
  parameter int WIDTH  = 11,
  parameter int LIMIT  = 999,
  parameter int DIGITS = 3
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_DGT = 4'd9;
  localparam logic [3:0] OP_DST = 4'd10;

  localparam int BW = 4 * DIGITS;
  localparam int PW = 2 * WIDTH;
  // Wide enough that no intermediate result wraps before clamping.
  localparam int XW = (PW + 2 > BW + 2) ? PW + 2 : BW + 2;
  localparam int CW = $clog2(((WIDTH > DIGITS) ? WIDTH : DIGITS) + 2);

  localparam logic signed [XW-1:0] LIM     = XW'(LIMIT);
  localparam logic signed [XW-1:0] NEG_LIM = -LIM;
  localparam logic signed [XW-1:0] HUNDRED = XW'(100);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_B2D, S_D2B, S_DONE} state_t;

  state_t state, state_nxt;

  logic                    valid_c, ready_c, accept;
  logic [3:0]              op_q;
  logic signed [WIDTH-1:0] acc_q, pos_q, out_q;
  logic                    neg_q;
  logic [3:0]              dig_q;
  logic [CW-1:0]           cnt_q;
  logic [PW-1:0]           mcand_q, prod_q, prod_nxt;
  logic [WIDTH-1:0]        mplier_q, bin_q;
  // BCD holds DIGITS digits, so dgt/dst see |acc| modulo 10^DIGITS.
  logic [BW-1:0]           bcd_q, bcd_adj, bcd_rep, horner_q, horner_nxt;
  logic [3:0]              sel_dig;
  logic                    pos_ok;
  logic signed [XW-1:0]    res_wide;
  logic                    res_load;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic signed [XW-1:0] sx(input logic signed [WIDTH-1:0] v);
    return {{(XW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [XW-1:0] v);
    if (v > LIM)     return LIM[WIDTH-1:0];
    if (v < NEG_LIM) return NEG_LIM[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  assign accept     = bus.in_valid && ready_c;
  assign prod_nxt   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign horner_nxt = horner_q * BW'(10) + BW'(bcd_q[BW-1 -: 4]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) begin
        case (bus.inst)
          OP_MUL:         state_nxt = S_MUL;
          OP_DGT, OP_DST: state_nxt = S_B2D;
          default:        state_nxt = S_DONE;
        endcase
      end
      S_MUL:  if (cnt_q == '0) state_nxt = S_DONE;
      S_B2D:  if (cnt_q == '0) state_nxt = (op_q == OP_DST) ? S_D2B : S_DONE;
      S_D2B:  if (cnt_q == '0) state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; in_ready is forced low while reset is asserted
  always_comb begin
    valid_c = (state == S_DONE);
    ready_c = !rst && (state == S_IDLE) && (!valid_c || bus.out_ready);
  end

  // BCD helpers: add-3 adjust, addressed digit select and digit replace
  always_comb begin
    bcd_adj = '0;
    bcd_rep = bcd_q;
    sel_dig = '0;
    pos_ok  = !pos_q[WIDTH-1] && (int'(pos_q) < DIGITS);
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      if (pos_ok && int'(pos_q) == i) begin
        bcd_rep[4*i +: 4] = dig_q;
        sel_dig           = bcd_q[4*i +: 4];
      end
    end
  end

  // Unclamped result and the cycle on which it is loaded into out
  always_comb begin
    res_load = 1'b0;
    res_wide = '0;
    case (state)
      S_IDLE: if (accept) begin
        res_load = (bus.inst != OP_MUL) && (bus.inst != OP_DGT) && (bus.inst != OP_DST);
        case (bus.inst)
          OP_ADD:  res_wide = sx(bus.acc) + sx(bus.arg1);
          OP_SUB:  res_wide = sx(bus.acc) - sx(bus.arg1);
          OP_NOT:  res_wide = (bus.acc == '0) ? HUNDRED : '0;
          default: res_wide = sx(bus.acc);
        endcase
      end
      S_MUL: if (cnt_q == '0) begin
        res_load = 1'b1;
        res_wide = {{(XW-PW){1'b0}}, prod_nxt};
        if (neg_q) res_wide = -res_wide;
      end
      S_B2D: if (cnt_q == '0 && op_q == OP_DGT) begin
        res_load = 1'b1;
        res_wide = {{(XW-4){1'b0}}, sel_dig};
        if (neg_q) res_wide = -res_wide;
      end
      S_D2B: if (cnt_q == '0) begin
        res_load = 1'b1;
        if (pos_ok) begin
          res_wide = {{(XW-BW){1'b0}}, horner_nxt};
          if (neg_q) res_wide = -res_wide;
        end else begin
          res_wide = sx(acc_q);
        end
      end
      default: ;
    endcase
  end

  // Operand capture, iterative datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      acc_q    <= '0;
      pos_q    <= '0;
      neg_q    <= 1'b0;
      dig_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      horner_q <= '0;
      out_q    <= '0;
    end else begin
      if (accept) begin
        op_q     <= bus.inst;
        acc_q    <= bus.acc;
        pos_q    <= bus.arg1;
        dig_q    <= 4'(mag(bus.arg2) % WIDTH'(10));
        mcand_q  <= PW'(mag(bus.acc));
        mplier_q <= mag(bus.arg1);
        prod_q   <= '0;
        bin_q    <= mag(bus.acc);
        bcd_q    <= '0;
        horner_q <= '0;
        cnt_q    <= (bus.inst == OP_MUL) ? CW'(WIDTH - 1) : CW'(WIDTH);
        case (bus.inst)
          OP_MUL:  neg_q <= bus.acc[WIDTH-1] ^ bus.arg1[WIDTH-1];
          OP_DST:  neg_q <= bus.arg2[WIDTH-1];
          default: neg_q <= bus.acc[WIDTH-1];
        endcase
      end
      case (state)
        S_MUL: begin
          prod_q   <= prod_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        S_B2D: begin
          if (cnt_q != '0) begin
            bcd_q <= {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            bcd_q <= bcd_rep;
            cnt_q <= CW'(DIGITS - 1);
          end
        end
        S_D2B: begin
          horner_q <= horner_nxt;
          bcd_q    <= bcd_q << 4;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
      if (res_load) out_q <= clamp(res_wide);
    end
  end

`ifdef ALU_SAT_FLAG_EN
  logic sat_q;

  // Saturation flag travels with out: set when the loaded result was clamped
  always_ff @(posedge clk) begin
    if (rst)           sat_q <= 1'b0;
    else if (res_load) sat_q <= (res_wide > LIM) || (res_wide < NEG_LIM);
  end

  assign bus.sat = sat_q;
`endif

  assign bus.out       = out_q;
  assign bus.out_valid = valid_c;
  assign bus.in_ready  = ready_c;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven vectors for alu_seq plus hand-written sequences for
// back-pressure, back-to-back issue and reset during a multiply.
module tb_alu_seq;
  localparam int WIDTH  = 11;
  localparam int LIMIT  = 999;
  localparam int DIGITS = 3;

  localparam logic [3:0] ADD = 4'd5, SUB = 4'd6, MUL = 4'd7, NOT = 4'd8, DGT = 4'd9, DST = 4'd10;
  localparam int L1 = 1, LM = WIDTH + 1, LG = WIDTH + 2, LS = WIDTH + DIGITS + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH), .LIMIT(LIMIT), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] inst;
    int acc;
    int arg1;
    int arg2;
    int exp_out;
    int exp_lat;
    int exp_sat;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [3:0] inst, input int acc, input int arg1,
                                  input int arg2, input int exp_out, input int exp_lat,
                                  input int exp_sat);
    vec_t v;
    v.inst = inst; v.acc = acc; v.arg1 = arg1; v.arg2 = arg2;
    v.exp_out = exp_out; v.exp_lat = exp_lat; v.exp_sat = exp_sat;
    vecs.push_back(v);
  endfunction

  task automatic drive_junk();
    bus.inst = 4'($urandom_range(0, 15));
    bus.acc  = WIDTH'($urandom);
    bus.arg1 = WIDTH'($urandom);
    bus.arg2 = WIDTH'($urandom);
  endtask

  task automatic offer(input logic [3:0] inst, input int acc, input int arg1, input int arg2);
    bus.inst     = inst;
    bus.acc      = WIDTH'(acc);
    bus.arg1     = WIDTH'(arg1);
    bus.arg2     = WIDTH'(arg2);
    bus.in_valid = 1'b1;
  endtask

  // Offer the request at a negedge and return #1 after the edge that accepts it.
  task automatic issue(input string name, input logic [3:0] inst, input int acc,
                       input int arg1, input int arg2, output bit ok);
    int n;
    @(negedge clk);
    offer(inst, acc, arg1, arg2);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    if (!ok) begin
      check({name, " in_ready"}, int'(bus.in_ready), 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    bit ok;
    int lat;
    string nm;
    nm = $sformatf("vec%0d op%0d", id, v.inst);
    issue(nm, v.inst, v.acc, v.arg1, v.arg2, ok);
    if (ok) begin
      bus.in_valid = 1'b0;
      drive_junk();
      wait_valid(lat);
      check({nm, " latency"}, lat, v.exp_lat);
      check({nm, " out"}, int'(bus.out), v.exp_out);
`ifdef ALU_SAT_FLAG_EN
      check({nm, " sat"}, int'(bus.sat), v.exp_sat);
`endif
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit ok;
    int lat;
    int seen;
    vec_t v;

    //       inst  acc    arg1   arg2  out   lat sat
    add_vec(ADD,   500,   600,    0,   999, L1, 1);
    add_vec(SUB,  -500,   600,    0,  -999, L1, 1);
    add_vec(ADD,   100,   -30,    0,    70, L1, 0);
    add_vec(SUB,     5,     7,    0,    -2, L1, 0);
    add_vec(ADD,   499,   500,    0,   999, L1, 0);
    add_vec(ADD,   500,   500,    0,   999, L1, 1);
    add_vec(ADD, -1024, -1024,    0,  -999, L1, 1);
    add_vec(SUB,  1023, -1024,    0,   999, L1, 1);
    add_vec(MUL,    37,   -27,    0,  -999, LM, 0);
    add_vec(MUL,    40,    30,    0,   999, LM, 1);
    add_vec(MUL,   -12,   -11,    0,   132, LM, 0);
    add_vec(MUL,     0, -1023,    0,     0, LM, 0);
    add_vec(MUL, -1024,     1,    0,  -999, LM, 1);
    add_vec(NOT,     0,     0,    0,   100, L1, 0);
    add_vec(NOT,     5,     0,    0,     0, L1, 0);
    add_vec(DGT,  -456,     0,    0,    -6, LG, 0);
    add_vec(DGT,  -456,     3,    0,     0, LG, 0);
    add_vec(DGT,  -456,     2,    0,    -4, LG, 0);
    add_vec(DGT,   789,     1,    0,     8, LG, 0);
    add_vec(DGT,   456,    -1,    0,     0, LG, 0);
    add_vec(DST,   123,     2,    7,   723, LS, 0);
    add_vec(DST,   123,     2,   -7,  -723, LS, 0);
    add_vec(DST,   123,     0,   19,   129, LS, 0);
    add_vec(DST,   -45,     1,    3,    35, LS, 0);
    add_vec(DST,   -45,     5,    3,   -45, LS, 0);
    add_vec(4'd0, 1020,     0,    0,   999, L1, 1);
    add_vec(4'd15,-1024,    0,    0,  -999, L1, 1);
    add_vec(4'd4,  -321,    0,    0,  -321, L1, 0);
    add_vec(4'd0,   999,    0,    0,   999, L1, 0);
    add_vec(4'd0, -1000,    0,    0,  -999, L1, 1);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.inst = '0; bus.acc = '0; bus.arg1 = '0; bus.arg2 = '0;

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset out", int'(bus.out), 0);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset in_ready", int'(bus.in_ready), 0);
`ifdef ALU_SAT_FLAG_EN
    check("reset sat", int'(bus.sat), 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Back-pressure: result must hold while out_ready is low, no new op may start
    bus.out_ready = 1'b0;
    issue("bp mul", MUL, 40, 30, 0, ok);
    if (ok) begin
      offer(ADD, 1, 1, 0);
      wait_valid(lat);
      check("bp latency", lat, LM);
      for (int k = 0; k < 5; k++) begin
        check($sformatf("bp hold%0d out", k), int'(bus.out), 999);
        check($sformatf("bp hold%0d out_valid", k), int'(bus.out_valid), 1);
        check($sformatf("bp hold%0d in_ready", k), int'(bus.in_ready), 0);
`ifdef ALU_SAT_FLAG_EN
        check($sformatf("bp hold%0d sat", k), int'(bus.sat), 1);
`endif
        @(posedge clk);
        #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp drained out_valid", int'(bus.out_valid), 0);
      check("bp pending in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp pending add valid", int'(bus.out_valid), 1);
      check("bp pending add out", int'(bus.out), 2);
      @(posedge clk);
      #1;
    end

    // Back-to-back not with out_ready high: one issue every other cycle
    issue("b2b not0", NOT, 0, 0, 0, ok);
    if (ok) begin
      check("b2b first valid", int'(bus.out_valid), 1);
      check("b2b first out", int'(bus.out), 100);
      check("b2b first in_ready", int'(bus.in_ready), 0);
      bus.acc = WIDTH'(5);
      @(posedge clk);
      #1;
      check("b2b gap valid", int'(bus.out_valid), 0);
      check("b2b gap in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("b2b second valid", int'(bus.out_valid), 1);
      check("b2b second out", int'(bus.out), 0);
      @(posedge clk);
      #1;
    end

    // Reset during MUL cycle 4 aborts the op
    issue("abort mul", MUL, 37, -27, 0, ok);
    if (ok) begin
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort in_ready in reset", int'(bus.in_ready), 0);
      check("abort out_valid in reset", int'(bus.out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) seen = 1;
      end
      check("abort no result", seen, 0);
      check("abort in_ready after", int'(bus.in_ready), 1);
      v.inst = ADD; v.acc = 500; v.arg1 = 600; v.arg2 = 0;
      v.exp_out = 999; v.exp_lat = L1; v.exp_sat = 1;
      run_vec(100, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
